// File: rtl/ctrl_pkg.sv
// ctrl_pkg: constants shared by the ID/EX control decoder and its condition checker.
//   - data-processing opcodes and their EXE_CMD encodings
//   - instruction-class (mode) and ARM condition-field encodings
//   - bit offsets of the low, width-independent part of the control bundle
//   - shadow-squash FSM state type and the opcode -> EXE_CMD decode helper
package ctrl_pkg;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] EXE_MOV = 4'd1;
  localparam logic [3:0] EXE_ADD = 4'd2;
  localparam logic [3:0] EXE_ADC = 4'd3;
  localparam logic [3:0] EXE_SUB = 4'd4;
  localparam logic [3:0] EXE_SBC = 4'd5;
  localparam logic [3:0] EXE_AND = 4'd6;
  localparam logic [3:0] EXE_ORR = 4'd7;
  localparam logic [3:0] EXE_EOR = 4'd8;
  localparam logic [3:0] EXE_MVN = 4'd9;

  localparam logic [1:0] MODE_DP   = 2'b00;
  localparam logic [1:0] MODE_MEM  = 2'b01;
  localparam logic [1:0] MODE_BR   = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bundle layout, LSB first: WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, B, S.
  // B and S sit above EXE_CMD, so their offsets depend on its width.
  localparam int WB_EN_POS    = 0;
  localparam int MEM_R_EN_POS = 1;
  localparam int MEM_W_EN_POS = 2;
  localparam int EXE_CMD_POS  = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } shadow_state_t;

  // CMP and TST reuse the SUB and AND datapath commands.
  function automatic logic [3:0] exe_cmd_of(input logic [3:0] op);
    logic [3:0] cmd;
    case (op)
      OP_MOV:  cmd = EXE_MOV;
      OP_MVN:  cmd = EXE_MVN;
      OP_ADD:  cmd = EXE_ADD;
      OP_ADC:  cmd = EXE_ADC;
      OP_SUB:  cmd = EXE_SUB;
      OP_SBC:  cmd = EXE_SBC;
      OP_AND:  cmd = EXE_AND;
      OP_ORR:  cmd = EXE_ORR;
      OP_EOR:  cmd = EXE_EOR;
      OP_CMP:  cmd = EXE_SUB;
      OP_TST:  cmd = EXE_AND;
      default: cmd = EXE_MOV;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/ctrl_unit_pipe_cond_check.sv
// cond_check: combinational ARM condition-field evaluation.
//   cond  [3:0] in  : condition field of the instruction
//   flags [3:0] in  : status flags {N,Z,C,V}
//   pass        out : 1 when the instruction should execute
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered ARM control decoder at the ID/EX boundary.
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid / in_ready     : instruction handshake (cond, op_code, mode, s_bit, flags)
//   stall, flush            : hazard stall (blocks acceptance), pipeline flush from EX
//   out_valid / out_ready   : control-bundle handshake
//   ctrl_out [CTRL_W-1:0]   : {S, B, EXE_CMD, MEM_W_EN, MEM_R_EN, WB_EN}
//   out_nop                 : bundle was forced to NOP (condition fail or branch shadow)
//   shadow_active           : branch-shadow squash in progress
module ctrl_unit_pipe
  import ctrl_pkg::*;
#(
  parameter  int EXE_CMD_W = 4,
  parameter  int BR_SHADOW = 1,
  localparam int CTRL_W    = EXE_CMD_W + 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [3:0]        op_code,
  input  logic [1:0]        mode,
  input  logic              s_bit,
  input  logic [3:0]        flags,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              out_nop,
  output logic              shadow_active
);

  localparam int CNT_W = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;
  localparam int B_POS = EXE_CMD_POS + EXE_CMD_W;
  localparam int S_POS = B_POS + 1;

  logic              cond_pass;
  logic              accept;
  logic              squash;
  logic              nop_d;
  logic              take_branch;
  logic              s_d, b_d, mw_d, mr_d, wb_d;
  logic [CTRL_W-1:0] ctrl_d;

  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              nop_p1;

  shadow_state_t     state;
  logic [CNT_W-1:0]  shadow_cnt;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // ---- stage p0: handshake and decode of the incoming instruction ----
  assign in_ready    = !stall && !flush && (!vld_p1 || out_ready);
  assign accept      = in_valid && in_ready;
  assign squash      = (state == ST_SQUASH);
  assign nop_d       = !cond_pass || squash;
  // A branch that is itself squashed never opens a new shadow.
  assign take_branch = (BR_SHADOW > 0) && !squash && (mode == MODE_BR) && cond_pass;

  always_comb begin
    s_d  = 1'b0;
    b_d  = 1'b0;
    mw_d = 1'b0;
    mr_d = 1'b0;
    wb_d = 1'b0;
    case (mode)
      MODE_DP: begin
        s_d  = s_bit;
        wb_d = (op_code != OP_CMP) && (op_code != OP_TST);
      end
      MODE_MEM: begin
        wb_d = s_bit;
        mr_d = s_bit;
        mw_d = !s_bit;
      end
      MODE_BR:   b_d = 1'b1;
      MODE_NONE: ;
    endcase
    // NOP keeps EXE_CMD so the datapath sees a harmless but defined command.
    if (nop_d) begin
      s_d  = 1'b0;
      b_d  = 1'b0;
      mw_d = 1'b0;
      mr_d = 1'b0;
      wb_d = 1'b0;
    end
    ctrl_d                              = '0;
    ctrl_d[WB_EN_POS]                   = wb_d;
    ctrl_d[MEM_R_EN_POS]                = mr_d;
    ctrl_d[MEM_W_EN_POS]                = mw_d;
    ctrl_d[EXE_CMD_POS +: EXE_CMD_W]    = EXE_CMD_W'(exe_cmd_of(op_code));
    ctrl_d[B_POS]                       = b_d;
    ctrl_d[S_POS]                       = s_d;
  end

  // ---- stage p1: single-entry output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      nop_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= ctrl_d;
      nop_p1  <= nop_d;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      shadow_cnt <= '0;
    end else if (flush) begin
      state      <= ST_RUN;
      shadow_cnt <= '0;
    end else if (accept) begin
      case (state)
        ST_RUN: begin
          if (take_branch) begin
            state      <= ST_SQUASH;
            shadow_cnt <= CNT_W'(BR_SHADOW);
          end
        end
        ST_SQUASH: begin
          shadow_cnt <= shadow_cnt - CNT_W'(1);
          if (shadow_cnt == CNT_W'(1)) begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign out_valid     = vld_p1;
  assign ctrl_out      = ctrl_p1;
  assign out_nop       = nop_p1;
  assign shadow_active = squash;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Scoreboard bench for ctrl_unit_pipe (EXE_CMD_W=6, BR_SHADOW=2): directed
// scenarios followed by random traffic, checked against a behavioural model.
module tb_ctrl_unit_pipe;

  localparam int EW     = 6;
  localparam int BRS    = 2;
  localparam int CW     = EW + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cond;
  logic [3:0]    op_code;
  logic [1:0]    mode;
  logic          s_bit;
  logic [3:0]    flags;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] ctrl_out;
  logic          out_nop;
  logic          shadow_active;

  ctrl_unit_pipe #(.EXE_CMD_W(EW), .BR_SHADOW(BRS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cond          (cond),
    .op_code       (op_code),
    .mode          (mode),
    .s_bit         (s_bit),
    .flags         (flags),
    .stall         (stall),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ctrl_out      (ctrl_out),
    .out_nop       (out_nop),
    .shadow_active (shadow_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic          nop;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   m_vld  = 1'b0;
  int   m_shadow = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_exe(input logic [3:0] op);
    case (op)
      4'b1101: return 1;
      4'b1111: return 9;
      4'b0100: return 2;
      4'b0101: return 3;
      4'b0010: return 4;
      4'b0110: return 5;
      4'b0000: return 6;
      4'b1100: return 7;
      4'b0001: return 8;
      4'b1010: return 4;
      4'b1000: return 6;
      default: return 1;
    endcase
  endfunction

  // One clock of stimulus: apply just after a rising edge, check and predict
  // just after the falling edge, then move on to the next rising edge.
  task automatic step(input bit iv, input logic [3:0] c, input logic [3:0] op,
                      input logic [1:0] m, input bit s, input logic [3:0] f,
                      input bit st, input bit fl, input bit ordy);
    bit   rdy_exp, acc, pass, nop, sb, bb, mw, mr, wb;
    exp_t e;
    in_valid = iv; cond = c; op_code = op; mode = m; s_bit = s;
    flags = f; stall = st; flush = fl; out_ready = ordy;
    @(negedge clk);
    #1;
    rdy_exp = !st && !fl && (!m_vld || ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
    check("shadow_active", {31'd0, shadow_active}, {31'd0, m_shadow > 0});
    acc = iv && rdy_exp;
    if (acc) begin
      pass = model_pass(c, f);
      nop  = !pass || (m_shadow > 0);
      sb = 0; bb = 0; mw = 0; mr = 0; wb = 0;
      case (m)
        2'b00: begin sb = s; wb = !(op == 4'b1010 || op == 4'b1000); end
        2'b01: begin wb = s; mr = s; mw = !s; end
        2'b10: bb = 1;
        default: ;
      endcase
      if (nop) begin sb = 0; bb = 0; mw = 0; mr = 0; wb = 0; end
      e.ctrl = {sb, bb, EW'(model_exe(op)), mw, mr, wb};
      e.nop  = nop;
      q.push_back(e);
    end
    if (fl) begin
      m_vld = 0;
      m_shadow = 0;
    end else if (acc) begin
      if (m_shadow > 0) m_shadow--;
      else if (m == 2'b10 && model_pass(c, f)) m_shadow = BRS;
      m_vld = 1;
    end else if (ordy) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a bundle is presented, it must match the oldest expectation;
  // it retires on out_ready or is discarded by flush.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: actual ctrl %0h, required no output", ctrl_out);
      end else begin
        check("ctrl_out", 32'(ctrl_out), 32'(q[0].ctrl));
        check("out_nop", {31'd0, out_nop}, {31'd0, q[0].nop});
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "timeout");
  end

  localparam logic [3:0] AL = 4'hE;
  localparam logic [3:0] NV = 4'hF;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; cond = AL; op_code = 4'b0100; mode = 2'b00;
    s_bit = 1'b1; flags = 4'h0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ctrl_out", 32'(ctrl_out), 32'd0);
    check("reset_out_nop", {31'd0, out_nop}, 32'd0);
    check("reset_shadow", {31'd0, shadow_active}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD with S, always
    step(1, AL, 4'b0100, 2'b00, 1, 4'h0, 0, 0, 1);
    // CMP EQ with Z set (pass) then clear (NOP)
    step(1, 4'h0, 4'b1010, 2'b00, 1, 4'b0100, 0, 0, 1);
    step(1, 4'h0, 4'b1010, 2'b00, 1, 4'b0000, 0, 0, 1);
    // backpressure: bundle held, no acceptance
    repeat (3) step(1, AL, 4'b0100, 2'b00, 0, 4'h0, 0, 0, 0);
    // memory load / store
    step(1, AL, 4'b0100, 2'b01, 1, 4'h0, 0, 0, 1);
    step(1, AL, 4'b0100, 2'b01, 0, 4'h0, 0, 0, 1);
    // taken branch then three MOVs: two squashed
    step(1, AL, 4'b0000, 2'b10, 0, 4'h0, 0, 0, 1);
    repeat (3) step(1, AL, 4'b1101, 2'b00, 0, 4'h0, 0, 0, 1);
    // failed branch: no shadow
    step(1, NV, 4'b0000, 2'b10, 0, 4'h0, 0, 0, 1);
    step(1, AL, 4'b1101, 2'b00, 0, 4'h0, 0, 0, 1);
    // flush with one shadow slot left and a bundle held
    step(1, AL, 4'b0000, 2'b10, 0, 4'h0, 0, 0, 1);
    step(1, AL, 4'b1101, 2'b00, 0, 4'h0, 0, 0, 1);
    step(1, AL, 4'b1101, 2'b00, 0, 4'h0, 0, 1, 0);
    step(1, AL, 4'b1101, 2'b00, 0, 4'h0, 0, 0, 1);
    // MVN zero-extended into a 6-bit EXE_CMD
    step(1, AL, 4'b1111, 2'b00, 0, 4'h0, 0, 0, 1);
    // stall drains the register
    repeat (2) step(1, AL, 4'b0100, 2'b00, 0, 4'h0, 1, 0, 1);

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 2) == 0) ? AL : 4'($urandom),
           4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0);
    end

    repeat (4) step(0, AL, 4'b0100, 2'b00, 0, 4'h0, 0, 0, 1);
    check("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
